// File: rtl/cmp_pkg.sv
// Shared encodings for the bit-serial magnitude comparator: one-hot {gt,eq,lt}
// result codes and the controller state type.
package cmp_pkg;

   localparam logic [2:0] CMP_GT   = 3'b100;
   localparam logic [2:0] CMP_EQ   = 3'b010;
   localparam logic [2:0] CMP_LT   = 3'b001;
   localparam logic [2:0] CMP_NONE = 3'b000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/comp.sv
// 1-bit magnitude compare cell: y = {a>b, a==b, a<b}, always one-hot.
module comp (
   input  logic       a,
   input  logic       b,
   output logic [2:0] y
);

   assign y = {a & ~b, ~(a ^ b), ~a & b};

endmodule

// File: rtl/mag_comp_seq.sv
// Bit-serial magnitude comparator controller: walks the 1-bit comp cell from
// MSB to LSB over latched operands and reports a one-hot {gt,eq,lt} result.
module mag_comp_seq
   import cmp_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     signed_cmp,
   input  logic [WIDTH-1:0]         a,
   input  logic [WIDTH-1:0]         b,
   output logic                     busy,
   output logic                     done,
   output logic [2:0]               result,
   output logic [$clog2(WIDTH)-1:0] bit_idx
);

   localparam int             IW      = $clog2(WIDTH);
   localparam logic [IW-1:0]  IDX_MSB = IW'(WIDTH - 1);

   state_t          r_state;
   state_t          w_state_nx;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic            r_signed;
   logic [IW-1:0]   r_idx;
   logic [2:0]      r_result;
   logic [2:0]      r_first;
   logic            r_found;

   logic            w_swap;
   logic            w_bit_a;
   logic            w_bit_b;
   logic [2:0]      w_cell;
   logic            w_diff;
   logic            w_last;
   logic            w_finish;
   logic [2:0]      w_final;

   // On a signed compare the sign bit carries inverted weight, so the cell
   // inputs are exchanged at the MSB: a sign of 1 reads as "less".
   assign w_swap  = r_signed && (r_idx == IDX_MSB);
   assign w_bit_a = w_swap ? r_b[r_idx] : r_a[r_idx];
   assign w_bit_b = w_swap ? r_a[r_idx] : r_b[r_idx];

   comp u_comp (
      .a (w_bit_a),
      .b (w_bit_b),
      .y (w_cell)
   );

   assign w_diff   = (w_cell != CMP_EQ);
   assign w_last   = (r_idx == '0);
   assign w_finish = EARLY_EXIT ? (w_diff || w_last) : w_last;
   assign w_final  = r_found ? r_first : (w_diff ? w_cell : CMP_EQ);

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         IDLE:    if (start) w_state_nx = SCAN;
         SCAN:    if (w_finish) w_state_nx = DONE;
         DONE:    w_state_nx = IDLE;
         default: w_state_nx = IDLE;
      endcase
   end

   // r_first keeps only the most significant difference; less significant
   // differences seen later in a fixed-latency scan are ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_signed <= 1'b0;
         r_idx    <= IDX_MSB;
         r_result <= CMP_NONE;
         r_first  <= CMP_NONE;
         r_found  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_a      <= a;
                  r_b      <= b;
                  r_signed <= signed_cmp;
                  r_idx    <= IDX_MSB;
                  r_first  <= CMP_NONE;
                  r_found  <= 1'b0;
               end
            end
            SCAN: begin
               if (!r_found && w_diff) begin
                  r_found <= 1'b1;
                  r_first <= w_cell;
               end
               if (w_finish) r_result <= w_final;
               else          r_idx    <= r_idx - IW'(1);
            end
            default: ;
         endcase
      end
   end

   assign busy    = (r_state != IDLE);
   assign done    = (r_state == DONE);
   assign result  = r_result;
   assign bit_idx = r_idx;

endmodule
